alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_op_class.sv | 23 ++
 rtl/alu_sequencer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode map, opcode-class ranges and sequencer state encoding for the
// ALU sequencer. Optional retire counter is enabled with ALU_SEQ_PERF_EN.
package alu_pkg;

  localparam logic [6:0] OP_ADD  = 7'd0;
  localparam logic [6:0] OP_SUB  = 7'd1;
  localparam logic [6:0] OP_AND  = 7'd2;
  localparam logic [6:0] OP_OR   = 7'd3;
  localparam logic [6:0] OP_XOR  = 7'd4;
  localparam logic [6:0] OP_SLL  = 7'd5;
  localparam logic [6:0] OP_SRL  = 7'd6;
  localparam logic [6:0] OP_SRA  = 7'd7;
  localparam logic [6:0] OP_CEQ  = 7'd8;
  localparam logic [6:0] OP_CNE  = 7'd9;
  localparam logic [6:0] OP_CLT  = 7'd10;
  localparam logic [6:0] OP_CGE  = 7'd11;
  localparam logic [6:0] OP_CLTU = 7'd12;
  localparam logic [6:0] OP_CGEU = 7'd13;
  localparam logic [6:0] OP_BR   = 7'd14;
  localparam logic [6:0] OP_BRC  = 7'd15;
  localparam logic [6:0] OP_IDLE = 7'h7F;

  // Inclusive opcode-class bounds; anything above BR_HI is illegal.
  localparam int unsigned WB_LO   = 0;
  localparam int unsigned WB_HI   = 7;
  localparam int unsigned FLAG_LO = 8;
  localparam int unsigned FLAG_HI = 13;
  localparam int unsigned BR_LO   = 14;
  localparam int unsigned BR_HI   = 15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RETIRE = 2'd3
  } seq_state_t;

endpackage

// File: rtl/alu_op_class.sv
// Combinational opcode classifier: sorts an opcode into write-back, flag,
// branch or illegal classes using the ranges from alu_pkg.
module alu_op_class
  import alu_pkg::*;
#(
  parameter int OP_W = 7
) (
  input  logic [OP_W-1:0] op,
  output logic            is_wb,
  output logic            is_flag,
  output logic            is_branch,
  output logic            is_illegal
);

  logic [31:0] op_ext;

  assign op_ext     = 32'(op);
  assign is_wb      = (op_ext <= WB_HI);
  assign is_flag    = (op_ext >= FLAG_LO) && (op_ext <= FLAG_HI);
  assign is_branch  = (op_ext >= BR_LO) && (op_ext <= BR_HI);
  assign is_illegal = (op_ext > BR_HI);

endmodule

// File: rtl/alu_sequencer.sv
// Four-state issue/wait/retire sequencer in front of a registered ALU.
// Define ALU_SEQ_PERF_EN to add the perf_retired legal-op retire counter.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int OP_W = 7,
  parameter int RD_W = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] in_op,
  input  logic [RD_W-1:0] in_rd,
  output logic [OP_W-1:0] alu_instr,
  input  logic [31:0]     alu_result,
  input  logic            alu_flag,
  input  logic            alu_addrch,
  input  logic [31:0]     alu_naddr,
  output logic            wb_en,
  output logic [RD_W-1:0] wb_rd,
  output logic [31:0]     wb_data,
  output logic            flag_q,
  output logic            br_valid,
  output logic [31:0]     br_addr,
  output logic            err,
  output logic            busy
`ifdef ALU_SEQ_PERF_EN
  ,
  output logic [31:0]     perf_retired
`endif
);

  seq_state_t      state;
  seq_state_t      state_next;
  logic [OP_W-1:0] op_q;
  logic [RD_W-1:0] rd_q;
  logic [OP_W-1:0] cls_op;
  logic            accept;
  logic            is_wb;
  logic            is_flag;
  logic            is_branch;
  logic            is_illegal;

  // In IDLE the incoming op is classified so illegal ops can skip straight to RETIRE.
  assign cls_op = (state == ST_IDLE) ? in_op : op_q;
  assign accept = in_valid && in_ready;

  alu_op_class #(
    .OP_W(OP_W)
  ) u_op_class (
    .op        (cls_op),
    .is_wb     (is_wb),
    .is_flag   (is_flag),
    .is_branch (is_branch),
    .is_illegal(is_illegal)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b1;
    alu_instr  = {OP_W{1'b1}};
    case (state)
      ST_IDLE: begin
        in_ready = !reset;
        busy     = 1'b0;
        if (in_valid && !reset) begin
          state_next = is_illegal ? ST_RETIRE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        alu_instr  = op_q;
        state_next = ST_WAIT;
      end
      ST_WAIT:   state_next = ST_RETIRE;
      ST_RETIRE: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Retire strobes are registered on the WAIT->RETIRE edge (ALU outputs are
  // already stable in WAIT), so they are visible exactly during RETIRE.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_q     <= '0;
      rd_q     <= '0;
      flag_q   <= 1'b0;
      wb_en    <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      br_valid <= 1'b0;
      br_addr  <= '0;
      err      <= 1'b0;
    end else begin
      wb_en    <= 1'b0;
      br_valid <= 1'b0;
      err      <= 1'b0;
      if (accept) begin
        op_q <= in_op;
        rd_q <= in_rd;
        err  <= is_illegal;
      end
      if (state == ST_WAIT) begin
        if (is_wb) begin
          wb_en   <= 1'b1;
          wb_rd   <= rd_q;
          wb_data <= alu_result;
        end
        if (is_branch && alu_addrch) begin
          br_valid <= 1'b1;
          br_addr  <= alu_naddr;
        end
      end
      if ((state == ST_RETIRE) && is_flag) begin
        flag_q <= alu_flag;
      end
    end
  end

`ifdef ALU_SEQ_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_retired <= '0;
    end else if ((state == ST_RETIRE) && !is_illegal) begin
      perf_retired <= perf_retired + 32'd1;
    end
  end
`endif

endmodule
